regbank_writeback_buffer: RTL and testbench
===========================================

// Module: regbank_writeback_buffer
// PURPOSE
//  Write-side front end of the register bank. Buffers results from execute/memory
//  (rd, data) in a small in-order FIFO. Drains one entry per cycle into the bank's
//  en/rd/data write port. Gives the decode stage rs/rt bypass lookups against
//  writes still pending, so reads return the youngest pending value.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, >=2
//  DATA_W     32  register data width
//  ADDR_W     5   register address width; matches the bank's rd/rs/rt
//  NUM_REGS   16  implemented registers; addresses >= NUM_REGS are illegal
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  rst         in   1       synchronous reset, active high
//  in_valid    in   1       producer offers a result this cycle
//  in_rd       in   ADDR_W  destination register of offered result
//  in_data     in   DATA_W  result value
//  in_ready    out  1       buffer can accept; transfer = in_valid & in_ready
//  wb_stall    in   1       bank write port unavailable this cycle
//  wb_en       out  1       to bank en
//  wb_rd       out  ADDR_W  to bank rd
//  wb_data     out  DATA_W  to bank data
//  lk_rs       in   ADDR_W  bypass lookup address A
//  lk_rt       in   ADDR_W  bypass lookup address B
//  lk_rs_hit   out  1       pending write to lk_rs exists
//  lk_rs_data  out  DATA_W  youngest pending data for lk_rs (0 when no hit)
//  lk_rt_hit   out  1       as lk_rs_hit, for lk_rt
//  lk_rt_data  out  DATA_W  as lk_rs_data, for lk_rt
//  count       out  clog2(DEPTH)+1  entries held
//  drop_err    out  1       one-cycle pulse: accepted result had an illegal rd
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): pointers and count=0, all entries invalid,
//    drop_err=0. rst wins over a same-cycle push/pop. Pending writes are discarded.
//    While empty: wb_en=0, in_ready=1, hit outputs 0, data outputs 0.
//  - in_ready = (count < DEPTH). It depends only on count, not on this cycle's pop.
//  - Push filter: an accepted rd==0 is silently dropped. An accepted rd>=NUM_REGS is
//    dropped and drop_err=1 on the next cycle (registered). Neither changes count.
//  - Drain: wb_en = (count!=0) & ~wb_stall. wb_rd/wb_data = head entry (comb).
//    On posedge with wb_en=1, head pops.
//  - Latency: result accepted at edge N is head-eligible in cycle N+1 when the FIFO
//    was empty. Earliest bank write is at edge N+1.
//  - Simultaneous push+pop when full: push refused (in_ready=0); pop proceeds.
//    Push+pop when not full: count unchanged, pointers both advance.
//  - Pointers wrap modulo DEPTH. count distinguishes full from empty.
//  - Strict FIFO order: two writes to the same rd reach the bank in issue order.
//  - Bypass (comb): scan the valid stored entries only; youngest match wins.
//    A result being pushed this cycle is not visible until the next cycle.
//    Lookup of rd 0 never hits.
//  - The head entry being written this cycle still counts as a hit this cycle.
//    The bank holds the value from the next cycle.
// STRUCTURE
//  - Shared package lapido_defs: DATA_W, ADDR_W, NUM_REGS constants, REG_ZERO.
//  - Sub-module wb_bypass_match (instanced twice, rs and rt): DEPTH-way compare plus
//    age-priority select from the head pointer. Storage and FIFO control stay in the
//    parent.
// TESTING
//  1 Reset: rst=1 mid-stream with count=3 -> next cycle count=0, wb_en=0,
//    lk hits 0, no further bank writes.
//  2 Push rd=5/0xA, wb_stall=0 -> cycle+1 wb_en=1, wb_rd=5, wb_data=0xA;
//    cycle+2 count=0.
//  3 wb_stall=1, push rd=3/1,3/2,4/7,3/9 -> count=4, in_ready=0; lk_rs=3 gives
//    hit=1, data=9; 5th push not accepted.
//  4 Release stall on full FIFO with in_valid=1 -> writes emerge 3/1,3/2,4/7,3/9 in
//    order. The 5th push is accepted only on the cycle after count drops.
//  5 Push rd=0/0xFF and rd=20/0x1 -> count stays 0, no wb_en,
//    drop_err pulses once (for rd=20 only).
//  6 Wrap: 10 back-to-back push with pop every cycle, unique rd/data -> count stays
//    <=1, every value written exactly once, in order.

Source files
------------

// File: rtl/lapido_defs.sv
// Shared register-bank constants.
// Widths, register count and the hardwired zero register.
package lapido_defs;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_bypass_match.sv
// Bypass lookup over the pending write FIFO.
// Scans oldest to youngest so the youngest match wins.
module wb_bypass_match #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = lapido_defs::DATA_W,
  parameter int ADDR_W = lapido_defs::ADDR_W,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0]              vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  rd,
  input  logic [DEPTH-1:0][DATA_W-1:0]  data,
  input  logic [PW-1:0]                 head,
  output logic                          hit,
  output logic [DATA_W-1:0]             hit_data
);
  import lapido_defs::*;

  logic [PW-1:0] idx;
  logic          is_zero;

  assign is_zero = (addr == ADDR_W'(REG_ZERO));

  // Walk by age from head; later (younger) matches override earlier ones
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (!is_zero && vld[idx] && rd[idx] == addr) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/regbank_writeback_buffer.sv
// Write-side front end of the register bank.
// In-order result FIFO draining into the bank, with rs/rt bypass.
module regbank_writeback_buffer #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = lapido_defs::DATA_W,
  parameter int ADDR_W   = lapido_defs::ADDR_W,
  parameter int NUM_REGS = lapido_defs::NUM_REGS,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              wb_stall,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] lk_rs,
  input  logic [ADDR_W-1:0] lk_rt,
  output logic              lk_rs_hit,
  output logic [DATA_W-1:0] lk_rs_data,
  output logic              lk_rt_hit,
  output logic [DATA_W-1:0] lk_rt_data,
  output logic [CW-1:0]     count,
  output logic              drop_err
);
  import lapido_defs::*;

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_rd;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [DEPTH-1:0]             vld;
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;

  logic accept;
  logic rd_zero;
  logic rd_bad;
  logic push;
  logic pop;
  logic busy;

  assign busy     = (count != '0);
  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign rd_zero  = (in_rd == ADDR_W'(REG_ZERO));
  assign rd_bad   = ({1'b0, in_rd} >= (ADDR_W+1)'(NUM_REGS));
  assign push     = accept & ~rd_zero & ~rd_bad;
  assign pop      = busy & ~wb_stall;

  assign wb_en   = pop;
  assign wb_rd   = busy ? mem_rd[head]   : '0;
  assign wb_data = busy ? mem_data[head] : '0;

  // FIFO pointers, occupancy, entry storage and drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      vld      <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept & rd_bad;
      if (push) begin
        mem_rd[tail]   <= in_rd;
        mem_data[tail] <= in_data;
        vld[tail]      <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  wb_bypass_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs (
    .addr     (lk_rs),
    .vld      (vld),
    .rd       (mem_rd),
    .data     (mem_data),
    .head     (head),
    .hit      (lk_rs_hit),
    .hit_data (lk_rs_data)
  );

  wb_bypass_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt (
    .addr     (lk_rt),
    .vld      (vld),
    .rd       (mem_rd),
    .data     (mem_data),
    .head     (head),
    .hit      (lk_rt_hit),
    .hit_data (lk_rt_data)
  );

endmodule

// File: tb/tb_regbank_writeback_buffer.sv
// Self-checking bench for regbank_writeback_buffer.
// Queue-based reference model plus directed and random stimulus.
module tb_regbank_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wb_stall;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] lk_rs;
  logic [AW-1:0] lk_rt;
  logic          lk_rs_hit;
  logic [DW-1:0] lk_rs_data;
  logic          lk_rt_hit;
  logic [DW-1:0] lk_rt_data;
  logic [CW-1:0] count;
  logic          drop_err;

  regbank_writeback_buffer #(
    .DEPTH    (DEPTH),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wb_stall   (wb_stall),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .lk_rs      (lk_rs),
    .lk_rt      (lk_rt),
    .lk_rs_hit  (lk_rs_hit),
    .lk_rs_data (lk_rs_data),
    .lk_rt_hit  (lk_rt_hit),
    .lk_rt_data (lk_rt_data),
    .count      (count),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  ent_t wlog[$];
  bit   exp_drop;
  bit   m_en;
  bit   m_acc;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void look(input logic [AW-1:0] a,
                               output bit h, output logic [DW-1:0] d);
    h = 0;
    d = '0;
    if (a != 0)
      foreach (q[i])
        if (q[i].rd == a) begin
          h = 1;
          d = q[i].d;
        end
  endfunction

  // Drive inputs after negedge, then check all outputs against the model
  task automatic drive(input bit v, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input bit st,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    bit            h;
    logic [DW-1:0] hd;
    int            n;
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wb_stall = st;
    lk_rs    = a;
    lk_rt    = b;
    #1;
    n     = q.size();
    m_en  = (n != 0) && !st;
    m_acc = v && (n < DEPTH);
    chk("count", count, n);
    chk("in_ready", in_ready, n < DEPTH);
    chk("wb_en", wb_en, m_en);
    chk("drop_err", drop_err, exp_drop);
    if (m_en) begin
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].d);
      wlog.push_back('{rd: wb_rd, d: wb_data});
    end
    look(a, h, hd);
    chk("rs_hit", lk_rs_hit, h);
    chk("rs_data", lk_rs_data, hd);
    look(b, h, hd);
    chk("rt_hit", lk_rt_hit, h);
    chk("rt_data", lk_rt_data, hd);
  endtask

  // Clock edge: retire head, then file the accepted result
  task automatic advance();
    @(posedge clk);
    if (m_en) void'(q.pop_front());
    exp_drop = m_acc && in_rd >= NR;
    if (m_acc && in_rd != 0 && in_rd < NR)
      q.push_back('{rd: in_rd, d: in_data});
    @(negedge clk);
  endtask

  task automatic step(input bit v, input logic [AW-1:0] rd,
                      input logic [DW-1:0] d, input bit st,
                      input logic [AW-1:0] a, input logic [AW-1:0] b);
    drive(v, rd, d, st, a, b);
    advance();
  endtask

  task automatic do_reset(input bit v);
    rst      = 1'b1;
    in_valid = v;
    in_rd    = 5'd2;
    in_data  = 32'h77;
    wb_stall = 1'b0;
    @(posedge clk);
    q.delete();
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ent_t exp_l[$];
    int   pulses;
    bit   done;
    n_cmp    = 0;
    n_bad    = 0;
    exp_drop = 0;
    lk_rs    = '0;
    lk_rt    = '0;
    @(negedge clk);
    do_reset(0);

    // Reset mid-stream with three pending and a push offered
    for (int i = 0; i < 3; i++) step(1, AW'(i + 1), DW'(i + 16), 1, 0, 0);
    chk("pre_rst_count", count, 3);
    do_reset(1);
    drive(0, 0, 0, 0, 1, 2);
    chk("rst_count", count, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_rs_hit", lk_rs_hit, 0);
    chk("rst_rs_data", lk_rs_data, 0);
    advance();
    step(0, 0, 0, 0, 2, 3);

    // Single result reaches the bank one cycle after acceptance
    step(1, 5, 32'hA, 0, 5, 0);
    drive(0, 0, 0, 0, 5, 0);
    chk("t2_wb_en", wb_en, 1);
    chk("t2_wb_rd", wb_rd, 5);
    chk("t2_wb_data", wb_data, 32'hA);
    chk("t2_head_hit", lk_rs_hit, 1);
    advance();
    drive(0, 0, 0, 0, 5, 0);
    chk("t2_count", count, 0);
    advance();

    // Fill under stall; youngest of rd 3 must win
    step(1, 3, 1, 1, 0, 0);
    step(1, 3, 2, 1, 0, 0);
    step(1, 4, 7, 1, 0, 0);
    step(1, 3, 9, 1, 0, 0);
    drive(1, 8, 32'h55, 1, 3, 4);
    chk("t3_count", count, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_rs_hit", lk_rs_hit, 1);
    chk("t3_rs_data", lk_rs_data, 9);
    chk("t3_rt_data", lk_rt_data, 7);
    advance();
    drive(1, 8, 32'h55, 1, 8, 0);
    chk("t3_no_5th", lk_rs_hit, 0);
    advance();

    // Release stall with a push held; drain order and late accept
    wlog.delete();
    done = 0;
    for (int i = 0; i < 8; i++) begin
      drive(!done, 8, 32'h55, 0, 8, 3);
      if (i == 0) chk("t4_refused", in_ready, 0);
      if (i == 1) chk("t4_accept", in_ready, 1);
      if (m_acc) done = 1;
      advance();
    end
    exp_l = '{'{rd: 3, d: 1}, '{rd: 3, d: 2}, '{rd: 4, d: 7},
              '{rd: 3, d: 9}, '{rd: 8, d: 32'h55}};
    chk("t4_nwrites", wlog.size(), exp_l.size());
    foreach (exp_l[i])
      if (i < wlog.size()) begin
        chk("t4_rd", wlog[i].rd, exp_l[i].rd);
        chk("t4_data", wlog[i].d, exp_l[i].d);
      end

    // Illegal and zero destinations are dropped
    pulses = 0;
    wlog.delete();
    drive(1, 0, 32'hFF, 0, 0, 0);
    pulses += int'(drop_err);
    advance();
    drive(1, 20, 32'h1, 0, 20, 0);
    pulses += int'(drop_err);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      pulses += int'(drop_err);
      chk("t5_count", count, 0);
      advance();
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_writes", wlog.size(), 0);

    // Back-to-back push/pop across pointer wrap
    wlog.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1, AW'(i + 1), DW'(32'h100 + i), 0, AW'(i), 0);
      else        drive(0, 0, 0, 0, 0, 0);
      chk("t6_count_le1", count <= 1, 1);
      advance();
    end
    chk("t6_nwrites", wlog.size(), 10);
    foreach (wlog[i]) begin
      chk("t6_rd", wlog[i].rd, i + 1);
      chk("t6_data", wlog[i].d, 32'h100 + i);
    end

    // Random traffic against the model, with occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] rd;
      if ($urandom_range(0, 3) == 0) rd = AW'($urandom_range(0, 31));
      else                           rd = AW'($urandom_range(1, 6));
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0, rd, $urandom,
           $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
